// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: DEPTH-entry FIFO with valid/ready on both sides,
// clear/trap_en flush and stall freeze. Define PIPE_STAGE_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module pipe_stage_fifo #(
    parameter int WIDTH = 354,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             trap_en,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             flush_s;
    logic             has_data_s;
    logic             in_ready_s;
    logic             push_s;
    logic             bypass_s;
    logic             pass_s;
    logic             push_mem_s;
    logic             pop_mem_s;
    logic             out_valid_s;
    logic [WIDTH-1:0] out_data_s;

    // Handshake decode, optional bypass and output selection
    always_comb begin
        flush_s    = rst | clear | trap_en;
        has_data_s = (count_q != {CNT_W{1'b0}});
        in_ready_s = ~rst & ~stall & (count_q != DEPTH_C);
        push_s     = in_valid & in_ready_s;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        bypass_s   = ~has_data_s & in_valid & ~stall & ~flush_s;
        pass_s     = bypass_s & out_ready;
`else
        bypass_s   = 1'b0;
        pass_s     = 1'b0;
`endif
        // A passed-through beat never occupies storage
        push_mem_s  = push_s & ~pass_s;
        pop_mem_s   = has_data_s & ~stall & out_ready;
        out_valid_s = (has_data_s & ~stall) | bypass_s;
        if (has_data_s) begin
            out_data_s = mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            out_data_s = in_data;
        end else begin
            out_data_s = {WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy next-state; flush dominates push/pop and stall
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_mem_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_mem_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_mem_s, pop_mem_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; stale entries are masked by the empty check on read
    always_ff @(posedge clk) begin
        if (push_mem_s && !flush_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = ~has_data_s;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: DEPTH=4 instance for fill/flush/stall,
// DEPTH=2 instance for pointer wrap-around.
module tb_pipe_stage_fifo;

    localparam int W = 354;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear, trap_en, stall;

    logic         d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_full, d4_empty;
    logic [W-1:0] d4_in_data, d4_out_data;
    logic [2:0]   d4_count;

    logic         d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_full, d2_empty;
    logic [W-1:0] d2_in_data, d2_out_data;
    logic [1:0]   d2_count;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .clear(clear), .trap_en(trap_en), .stall(stall),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
        .count(d4_count), .full(d4_full), .empty(d4_empty)
    );

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .clear(clear), .trap_en(trap_en), .stall(stall),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .count(d2_count), .full(d2_full), .empty(d2_empty)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] a5_val;
    logic [W-1:0] got_q[$];
    int           next_val;

    initial begin
        a5_val = 354'hCAFE_0000_0000_0000_0000_00A5;
        rst = 1'b1; clear = 1'b0; trap_en = 1'b0; stall = 1'b0;
        d4_in_valid = 1'b0; d4_in_data = '0; d4_out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0;

        // Reset held two cycles
        step();
        step();
        check("rst_in_ready", d4_in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_count", d4_count, 3'd0);
        check("rst_empty", d4_empty, 1'b1);
        check("rst_full", d4_full, 1'b0);
        check("rst_out_valid", d4_out_valid, 1'b0);
        check("rst_out_data", d4_out_data, '0);
        check("rst_in_ready_after", d4_in_ready, 1'b1);

        // Single beat
        step();
        d4_in_valid = 1'b1; d4_in_data = a5_val; d4_out_ready = 1'b1;
        #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        check("beat_bypass_valid", d4_out_valid, 1'b1);
        check("beat_bypass_data", d4_out_data, a5_val);
        step();
        d4_in_valid = 1'b0;
        #1;
        check("beat_bypass_count", d4_count, 3'd0);
`else
        check("beat_lat0_valid", d4_out_valid, 1'b0);
        step();
        d4_in_valid = 1'b0;
        #1;
        check("beat_valid", d4_out_valid, 1'b1);
        check("beat_data", d4_out_data, a5_val);
        check("beat_count1", d4_count, 3'd1);
        step();
        check("beat_count0", d4_count, 3'd0);
        check("beat_drained", d4_out_valid, 1'b0);
`endif

        // Fill to full: 1..5, only four accepted
        d4_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            d4_in_valid = 1'b1; d4_in_data = W'(i);
            #1;
            check($sformatf("fill_in_ready_%0d", i), d4_in_ready, (i <= 4) ? 1'b1 : 1'b0);
            step();
        end
        check("fill_count", d4_count, 3'd4);
        check("fill_full", d4_full, 1'b1);
        check("fill_empty", d4_empty, 1'b0);
        d4_out_ready = 1'b1;
        #1;
        check("full_no_passthru", d4_in_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) d4_in_valid = 1'b0;
            #1;
            check($sformatf("drain_valid_%0d", i), d4_out_valid, 1'b1);
            check($sformatf("drain_data_%0d", i), d4_out_data, W'(i));
            step();
        end
        d4_in_valid = 1'b0;
        #1;
        check("drain_empty", d4_empty, 1'b1);
        check("drain_out_data0", d4_out_data, '0);

        // Simultaneous push/pop at count=1
        d4_out_ready = 1'b0; d4_in_valid = 1'b1; d4_in_data = W'(6);
        step();
        d4_in_data = W'(7); d4_out_ready = 1'b1;
        #1;
        check("simul_head", d4_out_data, W'(6));
        check("simul_in_ready", d4_in_ready, 1'b1);
        step();
        d4_in_valid = 1'b0; d4_out_ready = 1'b0;
        #1;
        check("simul_count", d4_count, 3'd1);
        check("simul_next", d4_out_data, W'(7));

        // Trap flush at count=2 with incoming beat and stall
        d4_in_valid = 1'b1; d4_in_data = W'(8);
        step();
        check("flush_pre_count", d4_count, 3'd2);
        trap_en = 1'b1; stall = 1'b1; d4_in_data = W'(9);
        #1;
        check("flush_stall_ready", d4_in_ready, 1'b0);
        step();
        trap_en = 1'b0; stall = 1'b0; d4_in_valid = 1'b0;
        #1;
        check("flush_count", d4_count, 3'd0);
        check("flush_empty", d4_empty, 1'b1);
        check("flush_out_data", d4_out_data, '0);
        step();
        check("flush_beat_absent", d4_count, 3'd0);

        // Clear discards an accepted same-cycle push
        clear = 1'b1; d4_in_valid = 1'b1; d4_in_data = W'(17);
        step();
        clear = 1'b0; d4_in_valid = 1'b0;
        #1;
        check("clear_push_discard", d4_count, 3'd0);
        check("clear_out_valid", d4_out_valid, 1'b0);

        // Stall hold at count=1
        d4_in_valid = 1'b1; d4_in_data = W'(51);
        step();
        d4_in_valid = 1'b0; stall = 1'b1; d4_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_valid_%0d", i), d4_out_valid, 1'b0);
            check($sformatf("stall_count_%0d", i), d4_count, 3'd1);
            check($sformatf("stall_ready_%0d", i), d4_in_ready, 1'b0);
            step();
        end
        stall = 1'b0;
        #1;
        check("stall_release_valid", d4_out_valid, 1'b1);
        check("stall_release_data", d4_out_data, W'(51));
        step();
        d4_out_ready = 1'b0;
        #1;
        check("stall_once_count", d4_count, 3'd0);
        check("stall_once_valid", d4_out_valid, 1'b0);

        // Wrap-around on DEPTH=2 with toggling out_ready
        next_val = 0;
        for (int cyc = 0; cyc < 100 && got_q.size() < 10; cyc++) begin
            d2_in_valid  = (next_val < 10);
            d2_in_data   = W'(next_val);
            d2_out_ready = (cyc % 2 == 0);
            #1;
            if (d2_out_valid && d2_out_ready) got_q.push_back(d2_out_data);
            if (d2_in_valid && d2_in_ready) next_val++;
            step();
        end
        d2_in_valid = 1'b0; d2_out_ready = 1'b0;
        check("wrap_received", W'(got_q.size()), W'(10));
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            check($sformatf("wrap_data_%0d", i), got_q[i], W'(i));
        end
        #1;
        check("wrap_final_empty", d2_empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
